// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, states and helpers for the UART command sequencer
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CMD_OP_W      = 4;
  localparam int         TIMER_W       = 16;

  // Parser states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_OP  = 3'd1;
  localparam logic [2:0] ST_GET_A   = 3'd2;
  localparam logic [2:0] ST_GET_B   = 3'd3;
  localparam logic [2:0] ST_GET_CHK = 3'd4;

  typedef struct packed {
    logic [CMD_OP_W-1:0] op;
    logic [7:0]          a;
    logic [7:0]          b;
  } cmd_t;

  // Frame checksum covers the full opcode byte, upper nibble included
  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    return op ^ a ^ b;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_gap_timer.sv
// rtl/uart_cmd_sequencer_gap_timer.sv - inter-byte gap counter with clear, enable and expire
module gap_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 43400
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CLKS - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  assign expire = (count_q == LAST);

  // Clear wins over count; saturate at the expire value so the counter never wraps
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - 5-byte frame parser feeding a single-entry command slot
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 43400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [CMD_OP_W-1:0] cmd_op,
  output logic [7:0]          cmd_a,
  output logic [7:0]          cmd_b,
  output logic                err_chk,
  output logic                err_timeout,
  output logic                err_ovr,
  output logic [7:0]          frame_cnt,
  output logic                busy
);

  logic [2:0] state_q, state_d;
  logic [7:0] op_q, op_d, a_q, a_d, b_q, b_d;
  cmd_t       slot_q, slot_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       err_chk_q, err_chk_d, err_to_q, err_to_d, err_ovr_q, err_ovr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic expire, timeout_hit, slot_free, in_idle;

  assign in_idle = (state_q == ST_IDLE);

  gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid || in_idle),
    .en     (!in_idle),
    .expire (expire)
  );

  // A byte arriving in the expiry cycle takes priority over the timeout
  assign timeout_hit = expire && !rx_valid && !in_idle;
  // Slot may be refilled in the same cycle the ALU side takes the old command
  assign slot_free   = !cmd_valid_q || cmd_ready;

  // Parser FSM, checksum verdict and command slot next-state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    slot_d      = slot_q;
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    frame_cnt_d = frame_cnt_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    err_ovr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_GET_OP;
      end
      ST_GET_OP, ST_GET_A, ST_GET_B: begin
        if (rx_valid) begin
          if (state_q == ST_GET_OP) op_d = rx_data;
          if (state_q == ST_GET_A)  a_d  = rx_data;
          if (state_q == ST_GET_B)  b_d  = rx_data;
          state_d = state_q + 3'd1;
        end else if (timeout_hit) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end
      end
      ST_GET_CHK: begin
        if (rx_valid) begin
          state_d = ST_IDLE;
          if (rx_data != frame_chk(op_q, a_q, b_q)) begin
            err_chk_d = 1'b1;
          end else if (slot_free) begin
            slot_d      = '{op: op_q[CMD_OP_W-1:0], a: a_q, b: b_q};
            cmd_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_ovr_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, staging and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      slot_q      <= '0;
      cmd_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      slot_q      <= slot_d;
      cmd_valid_q <= cmd_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = slot_q.op;
  assign cmd_a       = slot_q.a;
  assign cmd_b       = slot_q.b;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_to_q;
  assign err_ovr     = err_ovr_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = !in_idle;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - scoreboard bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       err_chk;
  logic       err_timeout;
  logic       err_ovr;
  logic [7:0] frame_cnt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [27:0] cmd_q[$];
  logic [2:0]  err_q[$];
  logic [7:0]  model_cnt = 8'd0;

  uart_cmd_sequencer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .err_ovr     (err_ovr),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    send_byte(chk);
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    model_cnt = model_cnt + 8'd1;
    cmd_q.push_back({op, a, b, model_cnt});
  endtask

  // Monitor: errors pop the error queue, handshakes pop the command queue,
  // a held command must match the head of the command queue every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (err_chk || err_timeout || err_ovr) begin
        if (err_q.size() == 0) check("unexpected_err", {29'd0, err_chk, err_timeout, err_ovr}, 32'd0);
        else check("err_kind", {29'd0, err_chk, err_timeout, err_ovr}, {29'd0, err_q.pop_front()});
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) check("unexpected_cmd", 32'd1, 32'd0);
        else if (cmd_ready) check("cmd_handshake", {4'd0, cmd_op, cmd_a, cmd_b, frame_cnt}, {4'd0, cmd_q.pop_front()});
        else check("cmd_hold", {4'd0, cmd_op, cmd_a, cmd_b, frame_cnt}, {4'd0, cmd_q[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    rst = 1'b0;
    check("reset_outputs", {cmd_valid, cmd_op, cmd_a, cmd_b, err_chk, err_timeout, err_ovr, frame_cnt, busy}, 32'd0);

    // Basic frame, 1-cycle latency
    push_cmd(4'h3, 8'h12, 8'h34);
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    check("latency_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    idle(2);
    check("cnt_after_first", {24'd0, frame_cnt}, 32'd1);

    // Bad checksum
    err_q.push_back(3'b100);
    send_frame(8'h01, 8'h0F, 8'h0F, 8'h00);
    check("chk_no_valid", {31'd0, cmd_valid}, 32'd0);
    idle(2);
    check("cnt_after_bad", {24'd0, frame_cnt}, 32'd1);

    // Overrun with slot held
    cmd_ready = 1'b0;
    push_cmd(4'h1, 8'h11, 8'h22);
    send_frame(8'h01, 8'h11, 8'h22, 8'h32);
    err_q.push_back(3'b001);
    send_frame(8'h04, 8'h40, 8'h05, 8'h41);
    idle(3);
    check("ovr_keeps_cnt", {24'd0, frame_cnt}, 32'd2);
    cmd_ready = 1'b1;
    idle(2);

    // Ready raised on the checksum cycle: second frame replaces first, no overrun
    cmd_ready = 1'b0;
    push_cmd(4'h5, 8'hAA, 8'h55);
    send_frame(8'h05, 8'hAA, 8'h55, 8'hFA);
    push_cmd(4'h6, 8'h01, 8'h02);
    send_byte(8'hA5);
    send_byte(8'h06);
    send_byte(8'h01);
    send_byte(8'h02);
    cmd_ready = 1'b1;
    send_byte(8'h05);
    check("reload_valid", {31'd0, cmd_valid}, 32'd1);
    idle(3);
    check("cnt_after_reload", {24'd0, frame_cnt}, 32'd4);

    // Gap timeout
    err_q.push_back(3'b010);
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(19);
    check("to_not_yet", {30'd0, err_timeout, busy}, 32'd1);
    idle(1);
    check("to_pulse", {30'd0, err_timeout, busy}, 32'd2);
    idle(1);
    check("to_single", {31'd0, err_timeout}, 32'd0);

    // Byte exactly in the expiry cycle
    push_cmd(4'h2, 8'h10, 8'h20);
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(19);
    send_byte(8'h10);
    check("to_rescued", {30'd0, err_timeout, busy}, 32'd1);
    send_byte(8'h20);
    send_byte(8'h32);
    idle(2);

    // Noise in IDLE, then a frame carrying A5 as data
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    check("noise_idle", {31'd0, busy}, 32'd0);
    push_cmd(4'h9, 8'h3C, 8'hA5);
    send_frame(8'h09, 8'h3C, 8'hA5, 8'h90);
    idle(2);

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h07);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_cnt = 8'd0;
    check("rst_mid_frame", {cmd_valid, cmd_op, cmd_a, cmd_b, err_chk, err_timeout, err_ovr, frame_cnt, busy}, 32'd0);

    // Reset with pending command
    cmd_ready = 1'b0;
    push_cmd(4'h7, 8'h01, 8'h02);
    send_frame(8'h07, 8'h01, 8'h02, 8'h04);
    check("pending_before_rst", {31'd0, cmd_valid}, 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    cmd_q.delete();
    model_cnt = 8'd0;
    check("rst_pending", {cmd_valid, cmd_op, cmd_a, cmd_b, err_chk, err_timeout, err_ovr, frame_cnt, busy}, 32'd0);
    cmd_ready = 1'b1;
    idle(2);
    check("no_emit_after_rst", {31'd0, cmd_valid}, 32'd0);

    // 256 back-to-back frames: counter wraps to 0
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      push_cmd(v[3:0], v, ~v);
      send_frame(v, v, ~v, v ^ v ^ ~v);
      if (i == 0) check("first_after_rst", {24'd0, frame_cnt}, 32'd1);
    end
    idle(3);
    check("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    check("cmd_q_drained", cmd_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
